stall_control_unit: RTL

STALL_CONTROL_UNIT -- requirements
Module: stall_control_unit

---
 rtl/stall_control_unit_pkg.sv | 61 ++++++
 rtl/stall_control_unit_perf_counter.sv | 33 +++
 rtl/stall_control_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/stall_control_unit_pkg.sv
// Shared pipeline-control definitions: stall FSM state encodings, stall causes
// ordered by priority, and the control pattern each cause drives onto the pipeline.
package stall_control_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_HOLD  = 2'b01,
        ST_MEM_WAIT = 2'b10
    } ctrl_state_e;

    // Lower encoding wins: the cause selection chain in the FSM follows this order.
    typedef enum logic [2:0] {
        CAUSE_DMEM   = 3'd0,
        CAUSE_BRANCH = 3'd1,
        CAUSE_LU     = 3'd2,
        CAUSE_IMEM   = 3'd3,
        CAUSE_NONE   = 3'd4
    } stall_cause_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic mem_wb_stall;
        logic if_id_flush;
        logic id_ex_flush;
    } pipe_ctrl_t;

    function automatic pipe_ctrl_t cause_ctrl(input stall_cause_e cause);
        pipe_ctrl_t ctrl;
        ctrl = '{default: 1'b0};
        case (cause)
            CAUSE_DMEM: begin
                ctrl.pc_stall     = 1'b1;
                ctrl.if_id_stall  = 1'b1;
                ctrl.id_ex_stall  = 1'b1;
                ctrl.ex_mem_stall = 1'b1;
                ctrl.mem_wb_stall = 1'b1;
            end
            CAUSE_BRANCH: begin
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end
            CAUSE_LU: begin
                ctrl.pc_stall    = 1'b1;
                ctrl.if_id_stall = 1'b1;
                ctrl.id_ex_flush = 1'b1;
            end
            CAUSE_IMEM: begin
                ctrl.pc_stall    = 1'b1;
                ctrl.if_id_flush = 1'b1;
            end
            default: begin
                ctrl = '{default: 1'b0};
            end
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/stall_control_unit_perf_counter.sv
// Saturating event counter with enable and synchronous clear (clear wins).
module stall_perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {WIDTH{1'b0}};
        end else if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/stall_control_unit.sv
// Pipeline stall/flush controller with optional performance counters
// (enabled by defining STALL_PERF_COUNTERS_EN).
module stall_control_unit
    import stall_control_unit_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   LU_HAZ_SIG,
    input  logic                   BRANCH_TAKEN,
    input  logic                   DATA_MEM_BUSY,
    input  logic                   INSTR_MEM_BUSY,
    output logic                   PC_STALL,
    output logic                   IF_ID_STALL,
    output logic                   ID_EX_STALL,
    output logic                   EX_MEM_STALL,
    output logic                   MEM_WB_STALL,
    output logic                   IF_ID_FLUSH,
    output logic                   ID_EX_FLUSH,
    output logic [1:0]             STATE,
    output logic [COUNT_WIDTH-1:0] LU_BUBBLE_COUNT,
    output logic [COUNT_WIDTH-1:0] MEM_STALL_COUNT,
    output logic [COUNT_WIDTH-1:0] FLUSH_COUNT
);

    logic [1:0]   state_q;
    logic [1:0]   state_d;
    logic         lu_allowed_s;
    logic         illegal_state_s;
    stall_cause_e cause_s;
    pipe_ctrl_t   ctrl_s;

    // Cause selection, control decode and next state.
    always_comb begin
        state_d         = ST_RUN;
        lu_allowed_s    = 1'b1;
        illegal_state_s = 1'b0;
        cause_s         = CAUSE_NONE;

        case (state_q)
            ST_RUN:      lu_allowed_s = 1'b1;
            ST_MEM_WAIT: lu_allowed_s = 1'b1;
            // One bubble per hazard: the hazard is still asserted while the load completes.
            ST_LU_HOLD:  lu_allowed_s = 1'b0;
            default: begin
                lu_allowed_s    = 1'b1;
                illegal_state_s = 1'b1;
            end
        endcase

        if (RESET) begin
            cause_s = CAUSE_NONE;
        end else if (DATA_MEM_BUSY) begin
            cause_s = CAUSE_DMEM;
        end else if (BRANCH_TAKEN) begin
            cause_s = CAUSE_BRANCH;
        end else if (LU_HAZ_SIG && lu_allowed_s) begin
            cause_s = CAUSE_LU;
        end else if (INSTR_MEM_BUSY) begin
            cause_s = CAUSE_IMEM;
        end else begin
            cause_s = CAUSE_NONE;
        end

        ctrl_s = cause_ctrl(cause_s);

        if (illegal_state_s) begin
            state_d = ST_RUN;
        end else if (cause_s == CAUSE_DMEM) begin
            state_d = ST_MEM_WAIT;
        end else if (cause_s == CAUSE_LU) begin
            state_d = ST_LU_HOLD;
        end else begin
            state_d = ST_RUN;
        end
    end

    // State register; reset is folded in through the RUN default above.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign PC_STALL     = ctrl_s.pc_stall;
    assign IF_ID_STALL  = ctrl_s.if_id_stall;
    assign ID_EX_STALL  = ctrl_s.id_ex_stall;
    assign EX_MEM_STALL = ctrl_s.ex_mem_stall;
    assign MEM_WB_STALL = ctrl_s.mem_wb_stall;
    assign IF_ID_FLUSH  = ctrl_s.if_id_flush;
    assign ID_EX_FLUSH  = ctrl_s.id_ex_flush;
    assign STATE        = state_q;

`ifdef STALL_PERF_COUNTERS_EN
    logic lu_bubble_en_s;
    logic mem_stall_en_s;
    logic flush_en_s;

    assign lu_bubble_en_s = (cause_s == CAUSE_LU);
    assign mem_stall_en_s = (cause_s == CAUSE_DMEM);
    assign flush_en_s     = (cause_s == CAUSE_BRANCH);

    stall_perf_counter #(.WIDTH(COUNT_WIDTH)) u_lu_bubble_cnt (
        .clk   (CLK),
        .clr   (RESET),
        .en    (lu_bubble_en_s),
        .count (LU_BUBBLE_COUNT)
    );

    stall_perf_counter #(.WIDTH(COUNT_WIDTH)) u_mem_stall_cnt (
        .clk   (CLK),
        .clr   (RESET),
        .en    (mem_stall_en_s),
        .count (MEM_STALL_COUNT)
    );

    stall_perf_counter #(.WIDTH(COUNT_WIDTH)) u_flush_cnt (
        .clk   (CLK),
        .clr   (RESET),
        .en    (flush_en_s),
        .count (FLUSH_COUNT)
    );
`else
    assign LU_BUBBLE_COUNT = {COUNT_WIDTH{1'b0}};
    assign MEM_STALL_COUNT = {COUNT_WIDTH{1'b0}};
    assign FLUSH_COUNT     = {COUNT_WIDTH{1'b0}};
`endif

endmodule
